// File: rtl/gadget_delay_harness.sv
// Stimulus harness for a masked gadget. Each input bit is released to the gadget after its own
// programmable delay. The gadget output is then sampled after a fixed settle time.
module gadget_delay_harness #(
    parameter int unsigned IN_SIZE  = 24,
    parameter int unsigned OUT_SIZE = 8,
    parameter int unsigned DLY_W    = 3,
    parameter int unsigned LAT      = 2,
    localparam int unsigned IDX_W   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_SIZE-1:0]  in_data,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [DLY_W-1:0]    cfg_dly,
    output logic [IN_SIZE-1:0]  gad_in,
    input  logic [OUT_SIZE-1:0] gad_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out_data,
    output logic                busy
);

    localparam int unsigned D     = 1 << DLY_W;
    localparam int unsigned LAT_W = $clog2(LAT + 1);
    localparam int unsigned CNT_W = (DLY_W > LAT_W) ? DLY_W : LAT_W;

    localparam logic [CNT_W-1:0] ApplyLast  = CNT_W'(D - 1);
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StApply, StSettle, StHold} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_SIZE-1:0]  stage_q, stage_d;
    logic [IN_SIZE-1:0]  gad_in_q, gad_in_d;
    logic [OUT_SIZE-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [DLY_W-1:0]    dly_q [IN_SIZE];

    logic                cfg_hit;
    logic [IN_SIZE-1:0]  release_bits;

    // Delay writes only land while idle, so a write alongside an accept governs that vector.
    assign cfg_hit = (state_q == StIdle) && cfg_we && (32'(cfg_idx) < IN_SIZE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                dly_q[i] <= '0;
            end
        end else if (cfg_hit) begin
            dly_q[cfg_idx] <= cfg_dly;
        end
    end

    // Bits whose delay matches the current apply slot move from stage to the gadget this edge.
    always_comb begin
        release_bits = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            release_bits[i] = (state_q == StApply) && (dly_q[i] == cnt_q[DLY_W-1:0]);
        end
    end

    // Unreleased bits hold the previous vector, so only old-to-new transitions reach the gadget.
    assign gad_in_d = (stage_q & release_bits) | (gad_in_q & ~release_bits);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    stage_d = in_data;
                    cnt_d   = '0;
                    state_d = StApply;
                end
            end
            StApply: begin
                if (cnt_q == ApplyLast) begin
                    cnt_d   = '0;
                    state_d = StSettle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d       = '0;
                    out_data_d  = gad_out;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stage_q     <= '0;
            gad_in_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            gad_in_q    <= gad_in_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign gad_in    = gad_in_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gadget_delay_harness.sv
// Directed bench for gadget_delay_harness: per-cycle gad_in model, output scoreboard,
// back-pressure, reset mid-apply and configuration corner cases.
module tb_gadget_delay_harness;

    localparam int unsigned IN_SIZE  = 24;
    localparam int unsigned OUT_SIZE = 8;
    localparam int unsigned DLY_W    = 3;
    localparam int unsigned LAT      = 2;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned D        = 1 << DLY_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [IN_SIZE-1:0]  in_data;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [DLY_W-1:0]    cfg_dly;
    logic [IN_SIZE-1:0]  gad_in;
    logic [OUT_SIZE-1:0] gad_out;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_SIZE-1:0] out_data;
    logic                busy;

    // Gadget stub: the low byte of the applied inputs.
    assign gad_out = gad_in[OUT_SIZE-1:0];

    always #5 clk = ~clk;

    gadget_delay_harness #(
        .IN_SIZE  (IN_SIZE),
        .OUT_SIZE (OUT_SIZE),
        .DLY_W    (DLY_W),
        .LAT      (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_dly   (cfg_dly),
        .gad_in    (gad_in),
        .gad_out   (gad_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    int                  checks = 0;
    int                  errors = 0;
    logic [OUT_SIZE-1:0] sb [$];
    logic [IN_SIZE-1:0]  gad_model;
    int unsigned         dly_m [IN_SIZE];
    logic [OUT_SIZE-1:0] last_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        gad_model = '0;
        for (int i = 0; i < IN_SIZE; i++) dly_m[i] = 0;
    endtask

    task automatic cfg(input logic [IDX_W-1:0] idx, input logic [DLY_W-1:0] dv);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_dly = dv;
        tick();
        cfg_we  = 1'b0;
        if (idx < IN_SIZE) dly_m[idx] = dv;
    endtask

    // Accept one vector (optionally with a same-cycle delay write) and follow it to HOLD.
    task automatic send(input logic [IN_SIZE-1:0] data, input logic do_cfg,
                        input logic [IDX_W-1:0] idx, input logic [DLY_W-1:0] dv);
        logic [IN_SIZE-1:0]  old_v;
        logic [IN_SIZE-1:0]  exp_v;
        logic [OUT_SIZE-1:0] exp_o;
        old_v = gad_model;
        if (do_cfg && idx < IN_SIZE) dly_m[idx] = dv;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        cfg_we   = do_cfg;
        cfg_idx  = idx;
        cfg_dly  = dv;
        sb.push_back(data[OUT_SIZE-1:0]);
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check("in_ready_low", 32'(in_ready), 32'd0);
        check("busy_high", 32'(busy), 32'd1);
        for (int t = 1; t <= int'(D); t++) begin
            tick();
            for (int i = 0; i < IN_SIZE; i++) begin
                exp_v[i] = (dly_m[i] < t) ? data[i] : old_v[i];
            end
            check($sformatf("gad_in_E0+%0d", t), 32'(gad_in), 32'(exp_v));
        end
        gad_model = data;
        for (int t = 1; t < int'(LAT); t++) begin
            tick();
            check("out_valid_early", 32'(out_valid), 32'd0);
        end
        tick();
        check("out_valid_latency", 32'(out_valid), 32'd1);
        if (sb.size() > 0) begin
            exp_o = sb.pop_front();
            check("out_data", 32'(out_data), 32'(exp_o));
            last_out = exp_o;
        end else begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_rise", 32'(in_ready), 32'd1);
        check("busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_dly   = '0;
        out_ready = 1'b0;
        last_out  = '0;
        reset_model();
        tick();
        tick();
        rst = 1'b0;
        check("rst_gad_in", 32'(gad_in), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);

        // All delays zero: every bit rises at E0+1.
        send(24'hFFFFFF, 1'b0, '0, '0);
        drain();
        send(24'h000000, 1'b0, '0, '0);
        drain();

        // Skewed arrival of two bits from an all-zero gadget input.
        cfg(5'd23, 3'd5);
        cfg(5'd0, 3'd7);
        send(24'h800001, 1'b0, '0, '0);
        drain();

        // Back-pressure: output held, new vector and delay write both ignored.
        send(24'h5A5A5A, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 24'h123456;
            cfg_we   = 1'b1;
            cfg_idx  = 5'd0;
            cfg_dly  = 3'd1;
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data", 32'(out_data), 32'(last_out));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_gad_in", 32'(gad_in), 32'(gad_model));
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        drain();
        send(24'hA5A5A5, 1'b0, '0, '0);
        drain();

        // Reset three edges into APPLY.
        in_valid = 1'b1;
        in_data  = 24'h5A5A5A;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_model();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_gad_in", 32'(gad_in), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        send(24'hFFFFFF, 1'b0, '0, '0);
        drain();

        // Out-of-range index ignored; in-range write governs the same transaction.
        send(24'h000000, 1'b1, 5'd30, 3'd4);
        drain();
        send(24'hFFFFFF, 1'b1, 5'd2, 3'd4);
        drain();

        // A few random delay maps and vectors.
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                cfg(IDX_W'($urandom_range(IN_SIZE - 1, 0)), DLY_W'($urandom_range(D - 1, 0)));
            end
            send(IN_SIZE'($urandom), 1'b0, '0, '0);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
